pipelined_array_multiplier: RTL
===============================

# pipelined_array_multiplier

Parametrised, streaming array multiplier that computes the full 2*WIDTH-bit product of two WIDTH-bit operands, retiring BITS_PER_STAGE multiplier bits per pipeline stage. It extends the fixed one-bit-per-stage shift-and-add multiplier with:

- valid/ready handshakes on both sides, with whole-pipeline backpressure;
- a per-operation signed/unsigned mode;
- a pass-through tag that travels with each product.

It sits between arithmetic producers and consumers in the micro-benchmark datapaths and sustains one product per cycle when not stalled.

## Interface
- WIDTH, 8, operand width in bits; ≥2.
- BITS_PER_STAGE, 1, multiplier bits retired per stage. Must divide WIDTH; elaboration error otherwise.
- TAG_WIDTH, 4, width of the opaque tag carried with each operation; ≥1.
- Derived: STAGES = WIDTH / BITS_PER_STAGE.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  pipeline accepts operands this cycle.
- in_x  in  WIDTH  multiplier operand.
- in_y  in  WIDTH  multiplicand operand.
- in_signed  in  1  1 = both operands two's complement; 0 = unsigned.
- in_tag  in  TAG_WIDTH  opaque tag.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts product.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_WIDTH  tag of the operation producing out_p.

## Operation
- STAGES register stages s1..sSTAGES. Each stage holds: valid bit, x, y (extended to 2*WIDTH), signed flag, tag, partial sum.
- Stage k adds the partial products for x bits [k*B-1 : (k-1)*B], with B = BITS_PER_STAGE. Bit i contributes (x[i] ? y_ext << i : 0).
- Unsigned mode: y_ext is y zero-extended.
- Signed mode: y_ext is y sign-extended to 2*WIDTH. The partial product of x[WIDTH-1] is subtracted instead of added.
- All arithmetic is modulo 2^(2*WIDTH). out_p is the exact product in both modes; no overflow is possible.
- Global advance: advance = out_ready | ~out_valid. in_ready = advance (combinational, depends on out_ready).
- When advance = 1:
  - s1 loads the inputs, with s1.valid = in_valid.
  - Each sk loads s(k-1).
- When advance = 0: every stage holds, including its valid bit and data.
- Bubbles are not compressed. An empty stage is not filled while downstream is stalled.
- out_valid = sSTAGES.valid; out_p, out_tag = sSTAGES partial sum and tag.
- Transfers occur on in_valid & in_ready (input) and out_valid & out_ready (output), sampled at the rising edge.
- Input data changing while in_valid = 1 and in_ready = 0 is permitted. Nothing is captured.

## Timing
- Latency: operands accepted in cycle c appear on out_p/out_tag with out_valid = 1 in cycle c+STAGES, absent stalls. WIDTH=8, B=1 gives 8 cycles; WIDTH=8, B=4 gives 2 cycles.
- Throughput: 1 per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0, out_p/out_tag are held stable and in_ready = 0.
- Reset (reset_n = 0, asynchronous assert, synchronous deassert by the environment):
  - all valid bits 0; out_valid = 0;
  - out_p = 0, out_tag = 0, all stage data 0;
  - in_ready = 1 once reset is released.
- Reset mid-operation discards all in-flight operations. No product is emitted for them.
- Simultaneous output pop and input push in the same cycle is legal and loses nothing.

## Configuration
- Macro PIPELINED_ARRAY_MULT_SIGNED_EN.
- Defined: in_signed is honoured per operation as described above.
- Undefined: signed hardware is not built. in_signed is ignored, every operation is unsigned, and the signed flag is not stored in the stages.

## Test plan
- Unsigned, WIDTH=8, B=1: x=255, y=255, tag=3 in cycle 0, out_ready=1 → out_valid=1 in cycle 8 with out_p=0xFE01, out_tag=3.
- Signed (macro defined), WIDTH=8, B=2:
  - x=0x80 (−128), y=0x7F (127) → out_p=0xC080 (−16256) after 4 cycles.
  - x=0xFF, y=0xFF → out_p=0x0001.
- Back-to-back stream, WIDTH=8, B=4: 16 random operand pairs on consecutive cycles, tags 0..15 → 16 consecutive outputs, in order, matching a golden model.
- Backpressure: out_ready=0 for 5 cycles while the pipeline is full →
  - in_ready=0 throughout;
  - out_p/out_tag stable;
  - no loss or duplication after out_ready returns to 1.
- Reset mid-stream: assert reset_n=0 with 3 operations in flight → out_valid=0 and out_p=0 immediately, with no stale outputs after release.
- Macro undefined: x=0xFF, y=0xFF, in_signed=1 → out_p=0xFE01 (unsigned).

Source files
------------

// File: rtl/pipelined_array_multiplier.sv
// pipelined_array_multiplier
// Streaming shift-and-add multiplier that retires BITS_PER_STAGE multiplier
// bits per pipeline stage and produces the full 2*WIDTH-bit product. It has
// valid/ready handshakes, whole-pipeline backpressure and a pass-through tag.
// Optional feature macro: PIPELINED_ARRAY_MULT_SIGNED_EN
//   defined   -> in_signed selects two's complement operation per operand pair
//   undefined -> unsigned only; in_signed is ignored and not stored
module pipelined_array_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_x,
    input  logic [WIDTH-1:0]       in_y,
    input  logic                   in_signed,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_p,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;

    // Reject configurations that cannot be built.
    if (WIDTH < 2) begin : g_bad_width
        $error("pipelined_array_multiplier: WIDTH must be >= 2");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
        $error("pipelined_array_multiplier: TAG_WIDTH must be >= 1");
    end
    if (BITS_PER_STAGE < 1) begin : g_bad_bps
        $error("pipelined_array_multiplier: BITS_PER_STAGE must be >= 1");
    end else if (WIDTH % BITS_PER_STAGE != 0) begin : g_bad_div
        $error("pipelined_array_multiplier: BITS_PER_STAGE must divide WIDTH");
    end

    // Adds the partial products for multiplier bits [first_bit +: BITS_PER_STAGE].
    // In signed mode the MSB of x carries weight -2^(WIDTH-1), so its partial
    // product is subtracted; everything wraps modulo 2^PW.
    function automatic logic [PW-1:0] add_partials(
        input logic [WIDTH-1:0] x,
        input logic [PW-1:0]    y_ext,
        input logic             sgn,
        input int               first_bit,
        input logic [PW-1:0]    sum
    );
        logic [PW-1:0] acc;
        acc = sum;
        for (int j = 0; j < BITS_PER_STAGE; j++) begin
            if (x[first_bit + j]) begin
                if (sgn && (first_bit + j == WIDTH - 1))
                    acc = acc - (y_ext << (first_bit + j));
                else
                    acc = acc + (y_ext << (first_bit + j));
            end
        end
        return acc;
    endfunction

    // Stage registers; index k holds stage s(k+1).
    logic [STAGES-1:0]    st_valid;
    logic [WIDTH-1:0]     st_x   [STAGES];
    logic [PW-1:0]        st_y   [STAGES];
    logic [TAG_WIDTH-1:0] st_tag [STAGES];
    logic [PW-1:0]        st_sum [STAGES];

    // Values each stage loads on advance, and its updated partial sum.
    logic [STAGES-1:0]    src_valid;
    logic [WIDTH-1:0]     src_x   [STAGES];
    logic [PW-1:0]        src_y   [STAGES];
    logic [TAG_WIDTH-1:0] src_tag [STAGES];
    logic [PW-1:0]        src_sum [STAGES];
    logic [PW-1:0]        nxt_sum [STAGES];
    logic [STAGES-1:0]    src_sgn;

    logic [PW-1:0] in_y_ext;
    logic          advance;

`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
    logic [STAGES-1:0] st_sgn;

    assign in_y_ext = in_signed ? {{WIDTH{in_y[WIDTH-1]}}, in_y}
                                : {{WIDTH{1'b0}}, in_y};
`else
    logic unused_in_signed;

    assign unused_in_signed = in_signed;
    assign in_y_ext         = {{WIDTH{1'b0}}, in_y};
`endif

    // Stage k is fed by the inputs (k = 0) or by the previous stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src_valid[k] = in_valid;
            assign src_x[k]     = in_x;
            assign src_y[k]     = in_y_ext;
            assign src_tag[k]   = in_tag;
            assign src_sum[k]   = '0;
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
            assign src_sgn[k]   = in_signed;
`else
            assign src_sgn[k]   = 1'b0;
`endif
        end else begin : g_next
            assign src_valid[k] = st_valid[k-1];
            assign src_x[k]     = st_x[k-1];
            assign src_y[k]     = st_y[k-1];
            assign src_tag[k]   = st_tag[k-1];
            assign src_sum[k]   = st_sum[k-1];
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
            assign src_sgn[k]   = st_sgn[k-1];
`else
            assign src_sgn[k]   = 1'b0;
`endif
        end
        assign nxt_sum[k] = add_partials(src_x[k], src_y[k], src_sgn[k],
                                         k * BITS_PER_STAGE, src_sum[k]);
    end

    // The whole pipeline moves together unless the output is held.
    assign advance   = out_ready | ~st_valid[STAGES-1];
    assign in_ready  = advance;
    assign out_valid = st_valid[STAGES-1];
    assign out_p     = st_sum[STAGES-1];
    assign out_tag   = st_tag[STAGES-1];

    // Shift every stage forward on advance; hold everything otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: stage data is reset as well as the valid bits, because
            // out_p/out_tag must read zero during and straight after reset.
            st_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_x[k]   <= '0;
                st_y[k]   <= '0;
                st_tag[k] <= '0;
                st_sum[k] <= '0;
            end
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
            st_sgn <= '0;
`endif
        end else if (advance) begin
            // NOTE: non-blocking updates let every stage read the previous
            // stage's old value, which is what makes this a shift.
            st_valid <= src_valid;
            for (int k = 0; k < STAGES; k++) begin
                st_x[k]   <= src_x[k];
                st_y[k]   <= src_y[k];
                st_tag[k] <= src_tag[k];
                st_sum[k] <= nxt_sum[k];
            end
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
            st_sgn <= src_sgn;
`endif
        end
    end

endmodule
